// File: rtl/cpu_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_wb_arbiter_if
// Brief    : Pipeline/multi-cycle-unit/register-file bundle for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_wb_arbiter_if;
  logic        stall;
  logic [4:0]  p2_reg_a;
  logic [4:0]  p2_reg_b;
  logic        p2_use_a;
  logic        p2_use_b;
  logic [4:0]  p2_reg_d;
  logic        p2_write_en;
  logic        issue_valid;
  logic [4:0]  p4_reg_d;
  logic        p4_write_en;
  logic [31:0] p4_reg_data_d;
  logic        mc_valid;
  logic [4:0]  mc_reg_d;
  logic [31:0] mc_data;
  logic        mc_ready;
  logic [4:0]  rf_reg_d;
  logic        rf_write_en;
  logic [31:0] rf_data;
  logic        hazard_stall;
  logic        arb_stall;
  logic        sb_error;
  logic [31:0] pending;

  // Driven by the pipeline / multi-cycle unit side
  modport master (
    output stall, p2_reg_a, p2_reg_b, p2_use_a, p2_use_b, p2_reg_d,
           p2_write_en, issue_valid, p4_reg_d, p4_write_en, p4_reg_data_d,
           mc_valid, mc_reg_d, mc_data,
    input  mc_ready, rf_reg_d, rf_write_en, rf_data, hazard_stall,
           arb_stall, sb_error, pending
  );

  // The arbiter itself
  modport slave (
    input  stall, p2_reg_a, p2_reg_b, p2_use_a, p2_use_b, p2_reg_d,
           p2_write_en, issue_valid, p4_reg_d, p4_write_en, p4_reg_data_d,
           mc_valid, mc_reg_d, mc_data,
    output mc_ready, rf_reg_d, rf_write_en, rf_data, hazard_stall,
           arb_stall, sb_error, pending
  );
endinterface
`default_nettype wire

// File: rtl/cpu_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cpu_wb_arbiter
// Brief    : Register-file write-port arbiter between pipeline writeback and a
//            buffered multi-cycle result, with a pending-write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  wire              clock,
  input  wire              reset_n,
  cpu_wb_arbiter_if.slave  bus
);

  localparam logic [1:0] c_STARVE_LIMIT = 2'(STARVE_LIMIT);
  localparam logic [1:0] c_STARVE_MAX   = 2'd3;

  logic        r_hold_valid;
  logic [4:0]  r_hold_reg;
  logic [31:0] r_hold_data;
  logic [1:0]  r_starve_cnt;
  logic [31:0] r_pending;
  logic        r_sb_error;

  logic        w_pw;
  logic        w_force;
  logic        w_sel_hold;
  logic        w_sel_pipe;
  logic        w_xfer;
  logic        w_sb_set;
  logic        w_hazard;
  logic        w_err;
  logic [31:0] w_pending_nxt;

  assign w_pw    = bus.p4_write_en && !bus.stall && (bus.p4_reg_d != 5'd0);
  assign w_force = r_hold_valid && (r_starve_cnt == c_STARVE_LIMIT);

  // Hold wins when forced, or when the pipeline has nothing to write
  assign w_sel_hold = w_force || (!w_pw && r_hold_valid);
  assign w_sel_pipe = !w_force && w_pw;

  assign w_xfer = bus.mc_valid && !r_hold_valid;

  assign w_hazard = (bus.p2_use_a && r_pending[bus.p2_reg_a]) ||
                    (bus.p2_use_b && r_pending[bus.p2_reg_b]) ||
                    ((bus.p2_write_en || bus.issue_valid) && r_pending[bus.p2_reg_d]);

  assign w_sb_set = bus.issue_valid && !bus.stall && !bus.arb_stall && !w_hazard &&
                    (bus.p2_reg_d != 5'd0);

  assign w_err = (w_xfer && !r_pending[bus.mc_reg_d]) ||
                 (w_pw && r_pending[bus.p4_reg_d]);

  always_comb begin
    w_pending_nxt = r_pending;
    if (w_sel_hold) w_pending_nxt[r_hold_reg] = 1'b0;
    // A same-cycle set overrides the clear
    if (w_sb_set)   w_pending_nxt[bus.p2_reg_d] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  assign bus.mc_ready     = !r_hold_valid;
  assign bus.rf_reg_d     = w_sel_hold ? r_hold_reg  : bus.p4_reg_d;
  assign bus.rf_data      = w_sel_hold ? r_hold_data : bus.p4_reg_data_d;
  assign bus.rf_write_en  = (w_sel_hold && (r_hold_reg != 5'd0)) || w_sel_pipe;
  assign bus.arb_stall    = w_force && w_pw;
  assign bus.hazard_stall = w_hazard;
  assign bus.sb_error     = r_sb_error;
  assign bus.pending      = r_pending;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_valid <= 1'b0;
      r_hold_reg   <= 5'd0;
      r_hold_data  <= 32'd0;
      r_starve_cnt <= 2'd0;
      r_pending    <= 32'd0;
      r_sb_error   <= 1'b0;
    end else begin
      if (w_sel_hold) begin
        r_hold_valid <= 1'b0;
      end else if (w_xfer) begin
        r_hold_valid <= 1'b1;
        r_hold_reg   <= bus.mc_reg_d;
        r_hold_data  <= bus.mc_data;
      end

      if (!r_hold_valid || w_sel_hold) begin
        r_starve_cnt <= 2'd0;
      end else if (r_starve_cnt != c_STARVE_MAX) begin
        r_starve_cnt <= r_starve_cnt + 2'd1;
      end

      r_pending <= w_pending_nxt;

      if (w_err) r_sb_error <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_wb_arbiter
// Brief    : Directed self-checking bench for cpu_wb_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_wb_arbiter;

  logic clock;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  cpu_wb_arbiter_if bus ();

  cpu_wb_arbiter #(.STARVE_LIMIT(3)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.stall = 0; bus.p2_reg_a = 0; bus.p2_reg_b = 0; bus.p2_use_a = 0;
    bus.p2_use_b = 0; bus.p2_reg_d = 0; bus.p2_write_en = 0; bus.issue_valid = 0;
    bus.p4_reg_d = 0; bus.p4_write_en = 0; bus.p4_reg_data_d = 0;
    bus.mc_valid = 0; bus.mc_reg_d = 0; bus.mc_data = 0;
  endtask

  task automatic issue(input logic [4:0] rd);
    bus.issue_valid = 1; bus.p2_reg_d = rd;
    tick();
    bus.issue_valid = 0; bus.p2_reg_d = 0;
  endtask

  task automatic test_reset();
    reset_n = 0;
    idle();
    #1;
    checks++; if (bus.mc_ready !== 1'b1) begin errors++; $display("FAIL reset_mc_ready: got %b expected 1", bus.mc_ready); end
    checks++; if (bus.rf_write_en !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %b expected 0", bus.rf_write_en); end
    checks++; if (bus.arb_stall !== 1'b0) begin errors++; $display("FAIL reset_arb_stall: got %b expected 0", bus.arb_stall); end
    checks++; if (bus.pending !== 32'h0) begin errors++; $display("FAIL reset_pending: got %h expected 0", bus.pending); end
    checks++; if (bus.sb_error !== 1'b0) begin errors++; $display("FAIL reset_sb_error: got %b expected 0", bus.sb_error); end
    repeat (2) tick();
    #3 reset_n = 1;
    tick();
  endtask

  task automatic test_issue_result();
    issue(5'd5);
    #1;
    checks++; if (bus.pending[5] !== 1'b1) begin errors++; $display("FAIL issue_pending5_set: got %b expected 1", bus.pending[5]); end
    tick();
    bus.mc_valid = 1; bus.mc_reg_d = 5; bus.mc_data = 32'hDEADBEEF;
    #1;
    checks++; if (bus.mc_ready !== 1'b1) begin errors++; $display("FAIL issue_mc_ready: got %b expected 1", bus.mc_ready); end
    tick();
    idle();
    #1;
    checks++; if (bus.rf_write_en !== 1'b1 || bus.rf_reg_d !== 5'd5 || bus.rf_data !== 32'hDEADBEEF)
      begin errors++; $display("FAIL issue_rf_write: got we=%b rd=%0d data=%h expected we=1 rd=5 data=deadbeef", bus.rf_write_en, bus.rf_reg_d, bus.rf_data); end
    checks++; if (bus.mc_ready !== 1'b0) begin errors++; $display("FAIL issue_mc_ready_held: got %b expected 0", bus.mc_ready); end
    tick();
    checks++; if (bus.pending[5] !== 1'b0 || bus.rf_write_en !== 1'b0) begin errors++; $display("FAIL issue_pending5_clear: got pend=%b we=%b expected 0 0", bus.pending[5], bus.rf_write_en); end
    checks++; if (bus.sb_error !== 1'b0) begin errors++; $display("FAIL issue_sb_error: got %b expected 0", bus.sb_error); end
  endtask

  task automatic test_raw_hazard();
    issue(5'd7);
    bus.p2_use_a = 1; bus.p2_reg_a = 7;
    #1;
    checks++; if (bus.hazard_stall !== 1'b1) begin errors++; $display("FAIL raw_hazard_pending: got %b expected 1", bus.hazard_stall); end
    tick();
    bus.mc_valid = 1; bus.mc_reg_d = 7; bus.mc_data = 32'h0000_1234;
    #1;
    checks++; if (bus.hazard_stall !== 1'b1) begin errors++; $display("FAIL raw_hazard_xfer: got %b expected 1", bus.hazard_stall); end
    tick();
    bus.mc_valid = 0;
    #1;
    checks++; if (bus.hazard_stall !== 1'b1 || bus.rf_write_en !== 1'b1 || bus.rf_reg_d !== 5'd7)
      begin errors++; $display("FAIL raw_hazard_wcycle: got hz=%b we=%b rd=%0d expected 1 1 7", bus.hazard_stall, bus.rf_write_en, bus.rf_reg_d); end
    tick();
    checks++; if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL raw_hazard_release: got %b expected 0", bus.hazard_stall); end
    idle();
  endtask

  task automatic test_starvation();
    issue(5'd9);
    bus.mc_valid = 1; bus.mc_reg_d = 9; bus.mc_data = 32'h0000_0099;
    tick();
    bus.mc_valid = 0;
    for (int i = 1; i <= 3; i++) begin
      bus.p4_write_en = 1; bus.p4_reg_d = 5'(i); bus.p4_reg_data_d = 32'h100 + i;
      #1;
      checks++; if (bus.rf_write_en !== 1'b1 || bus.rf_reg_d !== 5'(i) || bus.arb_stall !== 1'b0 || bus.mc_ready !== 1'b0)
        begin errors++; $display("FAIL starve_pipe_win%0d: got we=%b rd=%0d arb=%b rdy=%b expected 1 %0d 0 0", i, bus.rf_write_en, bus.rf_reg_d, bus.arb_stall, bus.mc_ready, i); end
      tick();
    end
    bus.p4_reg_d = 4; bus.p4_reg_data_d = 32'h44;
    #1;
    checks++; if (bus.rf_write_en !== 1'b1 || bus.rf_reg_d !== 5'd9 || bus.rf_data !== 32'h99 || bus.arb_stall !== 1'b1)
      begin errors++; $display("FAIL starve_forced: got we=%b rd=%0d data=%h arb=%b expected 1 9 99 1", bus.rf_write_en, bus.rf_reg_d, bus.rf_data, bus.arb_stall); end
    tick();
    checks++; if (bus.rf_write_en !== 1'b1 || bus.rf_reg_d !== 5'd4 || bus.rf_data !== 32'h44 || bus.arb_stall !== 1'b0)
      begin errors++; $display("FAIL starve_deferred: got we=%b rd=%0d data=%h arb=%b expected 1 4 44 0", bus.rf_write_en, bus.rf_reg_d, bus.rf_data, bus.arb_stall); end
    checks++; if (bus.pending !== 32'h0 || bus.sb_error !== 1'b0)
      begin errors++; $display("FAIL starve_scoreboard: got pend=%h err=%b expected 0 0", bus.pending, bus.sb_error); end
    tick();
    idle();
  endtask

  task automatic test_reg0_stall();
    bus.p4_write_en = 1; bus.p4_reg_d = 0; bus.p4_reg_data_d = 32'hABCD;
    #1;
    checks++; if (bus.rf_write_en !== 1'b0) begin errors++; $display("FAIL reg0_write: got %b expected 0", bus.rf_write_en); end
    tick();
    bus.p4_reg_d = 3; bus.stall = 1;
    #1;
    checks++; if (bus.rf_write_en !== 1'b0) begin errors++; $display("FAIL stall_write: got %b expected 0", bus.rf_write_en); end
    tick();
    bus.stall = 0;
    #1;
    checks++; if (bus.rf_write_en !== 1'b1 || bus.rf_reg_d !== 5'd3) begin errors++; $display("FAIL unstalled_write: got we=%b rd=%0d expected 1 3", bus.rf_write_en, bus.rf_reg_d); end
    tick();
    idle();
  endtask

  task automatic test_protocol_error_reset();
    issue(5'd20);
    bus.mc_valid = 1; bus.mc_reg_d = 12; bus.mc_data = 32'h1212;
    #1;
    checks++; if (bus.sb_error !== 1'b0 || bus.pending !== 32'h0010_0000)
      begin errors++; $display("FAIL proto_before: got err=%b pend=%h expected 0 00100000", bus.sb_error, bus.pending); end
    tick();
    bus.mc_valid = 0;
    #1;
    checks++; if (bus.sb_error !== 1'b1) begin errors++; $display("FAIL proto_sb_error: got %b expected 1", bus.sb_error); end
    #1 reset_n = 0;
    #1;
    checks++; if (bus.sb_error !== 1'b0 || bus.pending !== 32'h0 || bus.mc_ready !== 1'b1 || bus.rf_write_en !== 1'b0)
      begin errors++; $display("FAIL async_reset: got err=%b pend=%h rdy=%b we=%b expected 0 0 1 0", bus.sb_error, bus.pending, bus.mc_ready, bus.rf_write_en); end
    tick();
    #3 reset_n = 1;
    tick();
    checks++; if (bus.pending !== 32'h0 || bus.rf_write_en !== 1'b0 || bus.mc_ready !== 1'b1 || bus.sb_error !== 1'b0)
      begin errors++; $display("FAIL post_reset_idle: got pend=%h we=%b rdy=%b err=%b expected 0 0 1 0", bus.pending, bus.rf_write_en, bus.mc_ready, bus.sb_error); end
  endtask

  initial begin
    test_reset();
    test_issue_result();
    test_raw_hazard();
    test_starvation();
    test_reg0_stall();
    test_protocol_error_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_wb_arbiter.md
CPU_WB_ARBITER -- requirements
Module: cpu_wb_arbiter

Interface
REQ-001 The block SHALL have one parameter: STARVE_LIMIT, default 3, the number of consecutive cycles a buffered multi-cycle result may lose the write port before it is forced through.
REQ-002 The block SHALL have these ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  external pipeline stall (excludes arb_stall).
- p2_reg_a, p2_reg_b  in  5 each  decode-stage source register numbers.
- p2_use_a, p2_use_b  in  1 each  the corresponding source is actually read.
- p2_reg_d  in  5  decode-stage destination register.
- p2_write_en  in  1  decode-stage instruction writes p2_reg_d.
- issue_valid  in  1  the decode-stage instruction is a multi-cycle operation (divide or load) targeting p2_reg_d.
- p4_reg_d  in  5  pipeline writeback register.
- p4_write_en  in  1  pipeline writeback request.
- p4_reg_data_d  in  32  pipeline writeback data.
- mc_valid  in  1  multi-cycle unit result valid.
- mc_reg_d  in  5  multi-cycle result register.
- mc_data  in  32  multi-cycle result data.
- mc_ready  out  1  the block accepts the multi-cycle result this cycle.
- rf_reg_d  out  5  register file write port: register number.
- rf_write_en  out  1  register file write port: write enable.
- rf_data  out  32  register file write port: data.
- hazard_stall  out  1  stall decode because of a scoreboard hazard.
- arb_stall  out  1  stall the whole pipeline for one cycle; the multi-cycle result has taken the port.
- sb_error  out  1  sticky protocol-error flag.
- pending  out  32  scoreboard; bit n is set while a multi-cycle write to register n is outstanding.
REQ-003 The register file stall input SHALL be tied low; this block SHALL be the only party that qualifies writes.

Function
REQ-004 Hold register: one entry {hold_valid, hold_reg, hold_data}.
- mc_ready SHALL equal !hold_valid.
- A transfer occurs when mc_valid && mc_ready; the entry is captured on the next edge.
REQ-005 Pipeline request: pw SHALL equal p4_write_en && !stall && p4_reg_d != 0.
REQ-006 Forced cycle: force SHALL equal hold_valid && starve_cnt == STARVE_LIMIT.
REQ-007 Arbitration, combinational, one write per cycle:
- If force is true, the hold entry SHALL be written.
- Otherwise, if pw is true, the pipeline result SHALL be written.
- Otherwise, if hold_valid is true, the hold entry SHALL be written.
- Otherwise rf_write_en SHALL be 0.
REQ-008 The block SHALL never write register 0; rf_write_en SHALL be 0 whenever the selected register is 0.
- A hold entry for register 0 SHALL still drain, with the write suppressed.
REQ-009 arb_stall SHALL equal force && pw.
- The pipeline write is then deferred to a later cycle, with p4 held by the stall.
REQ-010 starve_cnt is 2 bits wide and saturating.
- It SHALL clear when hold_valid is 0 or the hold entry is written.
- It SHALL increment when hold_valid is 1 and the pipeline won the port.
REQ-011 hold_valid SHALL clear on the edge where the hold entry is written.
- A new mc transfer SHALL NOT be accepted in that same cycle, because mc_ready was 0.
REQ-012 Scoreboard set: pending[p2_reg_d] SHALL be set when issue_valid && !stall && !arb_stall && !hazard_stall && p2_reg_d != 0.
REQ-013 Scoreboard clear: pending[hold_reg] SHALL clear on the edge where the hold entry is written.
- If a set and a clear of the same bit occur in one cycle, the set SHALL win.
REQ-014 hazard_stall SHALL be asserted when any of the following holds:
- p2_use_a && pending[p2_reg_a].
- p2_use_b && pending[p2_reg_b].
- (p2_write_en || issue_valid) && pending[p2_reg_d].
REQ-015 pending[0] SHALL always be 0.
REQ-016 sb_error SHALL be set, and remain set until reset, when either of these occurs:
- An mc transfer for a register whose pending bit is 0.
- pw is true for a register whose pending bit is 1.
REQ-017 There SHALL be no data bypass; consumers wait for the register file write.

Reset
REQ-018 While reset_n is 0 the block SHALL hold these values immediately, independent of clock:
- hold_valid=0, starve_cnt=0, pending=0, sb_error=0.
- Therefore mc_ready=1, rf_write_en=0, arb_stall=0.
REQ-019 Reset mid-operation SHALL discard any held result and all outstanding scoreboard bits.
- The first clock edge after reset_n rises SHALL behave as an idle cycle.

Verification
REQ-020 Issue then result:
- Stimulus: issue_valid with p2_reg_d=5; two cycles later mc_valid with mc_reg_d=5, mc_data=0xDEADBEEF; port otherwise idle.
- Required: pending[5]=1 on the edge after issue; mc_ready=1 at the transfer; rf_write_en=1, rf_reg_d=5, rf_data=0xDEADBEEF the cycle after; pending[5] clears on that edge.
REQ-021 RAW hazard:
- Stimulus: pending[7]=1, p2_use_a=1, p2_reg_a=7.
- Required: hazard_stall=1 until the register-7 write cycle; hazard_stall=0 on the following cycle.
REQ-022 Starvation, STARVE_LIMIT=3:
- Stimulus: hold_valid=1 for register 9, with pw true every cycle.
- Required: the pipeline wins 3 cycles; in the 4th cycle rf_reg_d=9 and arb_stall=1; the pipeline write lands in the 5th cycle.
REQ-023 Register 0 and stall:
- Stimulus: p4_write_en=1 with p4_reg_d=0; then p4_reg_d=3 with stall=1.
- Required: rf_write_en=0 in both cycles.
REQ-024 Protocol error and reset:
- Stimulus: mc_valid for register 12 with pending[12]=0; then reset_n=0 mid-cycle.
- Required: sb_error=1 after the transfer edge; sb_error=0, pending=0 and mc_ready=1 immediately on reset assertion.
